xor_decryption: RTL and testbench
=================================

# xor_decryption

Decryption engine for the XOR cipher datapath, the inverse of the encryption block. When enabled, it walks all cipher-text register entries once. At each address it reads the cipher byte, the key-ROM byte and the reference plain-text byte. It writes `cipher ^ key` into the recovered-text register and counts bytes that differ from the reference. Its outputs feed the same address muxes and register ports that the encryption block uses, so the LCD copier can display the recovered text.

## Interface
Parameters:
- `DEPTH`, 16: number of entries walked; must equal 2**`AW`.
- `AW`, 4: text address width.
- `DW`, 8: data width.
- `KEY_AW`, 4: key address width; must be ≤ `AW`. The key repeats every 2**`KEY_AW` bytes.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-low. One clock; reset is synchronous and active-low.
- `en`  in  1  level enable: high starts a run; low aborts a run or clears a finished state.
- `R_A`  out  `AW`  read address to the cipher register and the plain-text ROM.
- `key_R_A`  out  `AW`  read address to the key ROM.
- `cipher_R_D`  in  `DW`  cipher byte.
- `key_R_D`  in  `DW`  key byte.
- `ref_R_D`  in  `DW`  reference plain byte.
- `W_E`  out  1  recovered-text register write enable.
- `W_A`  out  `AW`  write address.
- `W_D`  out  `DW`  recovered byte.
- `finished`  out  1  run complete.
- `mismatch_count`  out  `AW`+1  number of recovered bytes not equal to `ref_R_D`.

## Operation
- All three sources present data exactly one cycle after the address is driven (registered read).
- `key_R_A` = `rd_ptr[KEY_AW-1:0]`, zero-extended to `AW`.
- States:
  - IDLE: `rd_ptr`=0 and `R_A`=0. If `en`=1, load `mismatch_count`=0 and go to RUN.
  - RUN: drive `R_A`=`rd_ptr`, then increment `rd_ptr`. The pipeline valid bit follows the issued addresses. After address `DEPTH`-1 is issued, go to DRAIN.
  - DRAIN: wait for the last write to retire, then go to DONE.
  - DONE: `finished`=1. Stay while `en`=1. If `en`=0, go to IDLE.
- Data stage, for each valid returned byte at address k:
  - Register `W_E`=1, `W_A`=k, `W_D`=`cipher_R_D ^ key_R_D`.
  - If `W_D` ≠ `ref_R_D`, increment `mismatch_count`. It saturates at `DEPTH`.
- `en`=0 sampled in RUN or DRAIN aborts the run:
  - Next state is IDLE.
  - The `W_E` register loads 0, so no write appears after the abort edge.
  - `finished` is not asserted.
  - `mismatch_count` holds its partial value until the next start.
- Restart after DONE requires `en` low for at least one cycle. `en` held high in DONE does not start a new run.
- `rd_ptr` wraps to 0 after `DEPTH`-1 without overflow logic (width `AW`).

## Timing
- Reset (`reset`=0 at an edge): state IDLE and `rd_ptr`=0. All outputs are 0: `R_A`, `key_R_A`, `W_E`, `W_A`, `W_D`, `finished`, `mismatch_count`. Reset overrides `en`.
- Reset asserted mid-run gives the same reset state on the next cycle, and no further writes occur.
- Cycle numbering: cycle 0 is the edge that samples `en`=1 in IDLE.
  - Cycle k+1, k = 0..15: address k is driven on `R_A`.
  - Cycle k+2: data for address k returns.
  - Cycle k+3: the write for address k appears on `W_E`/`W_A`/`W_D`.
  - Cycle 3: first write. Cycle 18: last write.
  - Cycle 19: `finished`=1, and `mismatch_count` is final.
- Throughput is one byte per cycle with no bubbles. Total latency from start to `finished` is `DEPTH`+3 cycles.
- Write timing: `W_E` is high for exactly `DEPTH` consecutive cycles per completed run. `W_A` is strictly incrementing, 0..`DEPTH`-1.

## Structure
- Shared include `xor_cipher_defs.vh` holds:
  - `DEPTH`, `AW` and `DW` defaults, shared with the encryption block and `register_8x16bit`.
  - State encodings IDLE, RUN, DRAIN and DONE as localparams.
- Single module with no sub-module. Optional internal split: FSM/address counter, and the registered XOR/compare stage.
- Integration in the datapath:
  - `R_A` and `key_R_A` enter the existing 4-bit muxes as a third source.
  - `W_*` drives a second `register_8x16bit` instance that holds the recovered text.

## Test plan
- Identity key: key bytes all 0x00, cipher bytes 0x41..0x50, reference = cipher -> `W_D` = 0x41..0x50 at `W_A` 0..15 in cycles 3..18. `finished` rises in cycle 19 and `mismatch_count`=0.
- Round trip: cipher = plain ^ key with key 0xA5,0x3C,… -> every `W_D` equals the plain byte, and `mismatch_count`=0.
- Key wrap with `KEY_AW`=2: `key_R_A` sequence is 0,1,2,3,0,1,… while `R_A` runs 0..15 -> recovered bytes correct.
- Mismatches: reference corrupted at addresses 3 and 15 -> `mismatch_count`=2 at `finished`. With all 16 corrupted, the count saturates at 16.
- Abort: `en` drops during cycle 8 -> `W_E`=0 from cycle 9 on and `finished` stays 0. Raising `en` later gives a full 16 writes starting at `W_A`=0.
- Reset mid-run in cycle 10 -> all outputs 0 on the next cycle. `en` held high in DONE never retriggers a run.

Source files
------------

// File: rtl/xor_decryption_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor_decryption_pkg
//  Description : Shared defaults and FSM encodings for the XOR decryption engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor_decryption_pkg;

    localparam int c_DEFAULT_DEPTH  = 16;
    localparam int c_DEFAULT_AW     = 4;
    localparam int c_DEFAULT_DW     = 8;
    localparam int c_DEFAULT_KEY_AW = 4;

    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_RUN   = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 2'd3;

    typedef logic [c_STATE_W-1:0] state_t;

endpackage
`default_nettype wire

// File: rtl/xor_decryption_stage.sv
`default_nettype none
// ============================================================================
//  Module      : xor_decryption_stage
//  Description : Registered XOR/compare stage; produces the recovered-text
//                write port and the saturating mismatch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_decryption_stage
    import xor_decryption_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int AW    = c_DEFAULT_AW,
    parameter int DW    = c_DEFAULT_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_addr_vld,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    input  logic          i_clear,
    input  logic [DW-1:0] i_cipher,
    input  logic [DW-1:0] i_key,
    input  logic [DW-1:0] i_ref,
    output logic          o_busy,
    output logic          o_we,
    output logic [AW-1:0] o_wa,
    output logic [DW-1:0] o_wd,
    output logic [AW:0]   o_mismatch_count
);

    localparam logic [AW:0] c_SAT = (AW+1)'(DEPTH);

    logic          r_data_vld;
    logic [AW-1:0] r_data_addr;
    logic          r_we;
    logic [AW-1:0] r_wa;
    logic [DW-1:0] r_wd;
    logic [AW:0]   r_mm_cnt;
    logic [DW-1:0] w_plain;
    logic          w_diff;

    assign w_plain = i_cipher ^ i_key;
    assign w_diff  = (w_plain != i_ref);

    // Valid/address travel alongside the one-cycle read latency of the sources.
    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_data_vld  <= 1'b0;
            r_data_addr <= '0;
        end else begin
            r_data_vld  <= i_addr_vld;
            r_data_addr <= i_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else if (i_flush) begin
            r_we <= 1'b0;
        end else begin
            r_we <= r_data_vld;
            if (r_data_vld) begin
                r_wa <= r_data_addr;
                r_wd <= w_plain;
            end
        end
    end

    // Partial count survives an abort; only a new start clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mm_cnt <= '0;
        end else if (i_clear) begin
            r_mm_cnt <= '0;
        end else if (!i_flush && r_data_vld && w_diff && (r_mm_cnt != c_SAT)) begin
            r_mm_cnt <= r_mm_cnt + 1'b1;
        end
    end

    assign o_busy           = r_data_vld;
    assign o_we             = r_we;
    assign o_wa             = r_wa;
    assign o_wd             = r_wd;
    assign o_mismatch_count = r_mm_cnt;

endmodule
`default_nettype wire

// File: rtl/xor_decryption.sv
`default_nettype none
// ============================================================================
//  Module      : xor_decryption
//  Description : XOR cipher decryption engine: walks every cipher entry once,
//                writes cipher^key to the recovered-text register.
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_decryption
    import xor_decryption_pkg::*;
#(
    parameter int DEPTH  = c_DEFAULT_DEPTH,
    parameter int AW     = c_DEFAULT_AW,
    parameter int DW     = c_DEFAULT_DW,
    parameter int KEY_AW = c_DEFAULT_KEY_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [AW-1:0] R_A,
    output logic [AW-1:0] key_R_A,
    input  logic [DW-1:0] cipher_R_D,
    input  logic [DW-1:0] key_R_D,
    input  logic [DW-1:0] ref_R_D,
    output logic          W_E,
    output logic [AW-1:0] W_A,
    output logic [DW-1:0] W_D,
    output logic          finished,
    output logic [AW:0]   mismatch_count
);

    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_ra;
    logic          r_addr_vld;
    logic          w_start;
    logic          w_abort;
    logic          w_stage_busy;

    assign w_start = (r_state == c_ST_IDLE) && en;
    assign w_abort = ((r_state == c_ST_RUN) || (r_state == c_ST_DRAIN)) && !en;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_rd_ptr   <= '0;
            r_ra       <= '0;
            r_addr_vld <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_rd_ptr   <= '0;
                    r_ra       <= '0;
                    r_addr_vld <= 1'b0;
                    if (en) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (!en) begin
                        r_state    <= c_ST_IDLE;
                        r_rd_ptr   <= '0;
                        r_ra       <= '0;
                        r_addr_vld <= 1'b0;
                    end else begin
                        r_ra       <= r_rd_ptr;
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                        r_addr_vld <= 1'b1;
                        if (r_rd_ptr == c_LAST_ADDR) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    r_addr_vld <= 1'b0;
                    if (!en) begin
                        r_state  <= c_ST_IDLE;
                        r_rd_ptr <= '0;
                        r_ra     <= '0;
                    end else if (!r_addr_vld && !w_stage_busy) begin
                        // Last write is on the port this cycle.
                        r_state <= c_ST_DONE;
                    end
                end
                default: begin
                    r_addr_vld <= 1'b0;
                    if (!en) begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign R_A      = r_ra;
    assign finished = (r_state == c_ST_DONE);

    // The key ROM repeats every 2**KEY_AW bytes.
    generate
        if (KEY_AW < AW) begin : g_key_narrow
            assign key_R_A = {{(AW-KEY_AW){1'b0}}, r_ra[KEY_AW-1:0]};
        end else begin : g_key_full
            assign key_R_A = r_ra;
        end
    endgenerate

    xor_decryption_stage #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_stage (
        .clk              (clk),
        .reset            (reset),
        .i_addr_vld       (r_addr_vld),
        .i_addr           (r_ra),
        .i_flush          (w_abort),
        .i_clear          (w_start),
        .i_cipher         (cipher_R_D),
        .i_key            (key_R_D),
        .i_ref            (ref_R_D),
        .o_busy           (w_stage_busy),
        .o_we             (W_E),
        .o_wa             (W_A),
        .o_wd             (W_D),
        .o_mismatch_count (mismatch_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_xor_decryption.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_decryption
//  Description : Self-checking bench for xor_decryption (full-width key and a
//                2-bit wrapping key instance side by side).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_decryption;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;

    logic [3:0] R_A, key_R_A, W_A, R_A2, key_R_A2, W_A2;
    logic [7:0] cipher_R_D, key_R_D, ref_R_D, W_D;
    logic [7:0] cipher_R_D2, key_R_D2, ref_R_D2, W_D2;
    logic       W_E, W_E2, finished, finished2;
    logic [4:0] mm, mm2;

    logic [7:0] cipher_mem [16];
    logic [7:0] key_mem    [16];
    logic [7:0] ref_mem    [16];
    logic [7:0] kpat       [16] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h69,
                                    8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];
    wr_t e1, e2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int wr_cnt2 = 0;
    int first_wr = -1;
    int t0 = 0;

    always #5 clk = ~clk;

    xor_decryption #(.DEPTH(16), .AW(4), .DW(8), .KEY_AW(4)) dut (
        .clk(clk), .reset(reset), .en(en), .R_A(R_A), .key_R_A(key_R_A),
        .cipher_R_D(cipher_R_D), .key_R_D(key_R_D), .ref_R_D(ref_R_D),
        .W_E(W_E), .W_A(W_A), .W_D(W_D), .finished(finished), .mismatch_count(mm)
    );

    xor_decryption #(.DEPTH(16), .AW(4), .DW(8), .KEY_AW(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .R_A(R_A2), .key_R_A(key_R_A2),
        .cipher_R_D(cipher_R_D2), .key_R_D(key_R_D2), .ref_R_D(ref_R_D2),
        .W_E(W_E2), .W_A(W_A2), .W_D(W_D2), .finished(finished2), .mismatch_count(mm2)
    );

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        cipher_R_D  <= cipher_mem[R_A];
        key_R_D     <= key_mem[key_R_A];
        ref_R_D     <= ref_mem[R_A];
        cipher_R_D2 <= cipher_mem[R_A2];
        key_R_D2    <= key_mem[key_R_A2];
        ref_R_D2    <= ref_mem[R_A2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input int a, input int mask);
        return cipher_mem[a] ^ key_mem[a & mask];
    endfunction

    function automatic int model_mm(input int mask, input int n);
        int c = 0;
        for (int a = 0; a < n; a++)
            if (model(a, mask) != ref_mem[a] && c < 16) c++;
        return c;
    endfunction

    // Scoreboard side: every write must match the next expected entry.
    always @(negedge clk) begin
        if (W_E) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            if (q1.size() == 0) check("wr1_extra", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("wr1_addr", W_A, e1.a);
                check("wr1_data", W_D, e1.d);
            end
        end
        if (W_E2) begin
            wr_cnt2++;
            if (q2.size() == 0) check("wr2_extra", 32'd1, 32'd0);
            else begin
                e2 = q2.pop_front();
                check("wr2_addr", W_A2, e2.a);
                check("wr2_data", W_D2, e2.d);
            end
        end
    end

    task automatic push_all();
        for (int a = 0; a < 16; a++) begin
            q1.push_back({4'(a), model(a, 15)});
            q2.push_back({4'(a), model(a, 3)});
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ra"}, R_A, 0);
        check({tag, "_kra"}, key_R_A, 0);
        check({tag, "_we"}, W_E, 0);
        check({tag, "_wa"}, W_A, 0);
        check({tag, "_wd"}, W_D, 0);
        check({tag, "_fin"}, finished, 0);
        check({tag, "_mm"}, mm, 0);
        check({tag, "_we2"}, W_E2, 0);
    endtask

    task automatic run_full(input string tag);
        int n;
        int exp1, exp2;
        exp1 = model_mm(15, 16);
        exp2 = model_mm(3, 16);
        wr_cnt = 0; wr_cnt2 = 0; first_wr = -1;
        push_all();
        en = 1'b1;
        t0 = cyc + 1;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                check({tag, "_ra"}, R_A, c - 1);
                check({tag, "_kra"}, key_R_A, (c - 1) & 15);
                check({tag, "_kra2"}, key_R_A2, (c - 1) & 3);
            end
        end
        n = 0;
        while (!finished && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_fin"}, finished, 1);
        check({tag, "_fin_cyc"}, cyc - t0, 19);
        check({tag, "_fin2"}, finished2, 1);
        check({tag, "_mm"}, mm, exp1);
        check({tag, "_mm2"}, mm2, exp2);
        #1;
        check({tag, "_wrcnt"}, wr_cnt, 16);
        check({tag, "_wrcnt2"}, wr_cnt2, 16);
        check({tag, "_first_wr"}, first_wr - t0, 3);
        check({tag, "_q_left"}, q1.size() + q2.size(), 0);
        // en held high in DONE must not retrigger.
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_hold_wr"}, wr_cnt, 16);
        check({tag, "_hold_fin"}, finished, 1);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check({tag, "_idle_fin"}, finished, 0);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin
            cipher_mem[a] = 8'h00; key_mem[a] = 8'h00; ref_mem[a] = 8'h00;
        end
        // Reset overrides en.
        reset = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        en = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Identity key
        for (int a = 0; a < 16; a++) begin
            key_mem[a] = 8'h00; cipher_mem[a] = 8'h41 + 8'(a); ref_mem[a] = 8'h41 + 8'(a);
        end
        run_full("ident");

        // Round trip with a full 16-byte key
        for (int a = 0; a < 16; a++) begin
            key_mem[a] = kpat[a];
            ref_mem[a] = 8'h30 + 8'(a * 3);
            cipher_mem[a] = ref_mem[a] ^ kpat[a];
        end
        run_full("round");

        // Key repeating every 4 bytes
        for (int a = 0; a < 16; a++) begin
            key_mem[a] = kpat[a & 3];
            ref_mem[a] = 8'hC0 ^ 8'(a * 7);
            cipher_mem[a] = ref_mem[a] ^ kpat[a & 3];
        end
        run_full("wrap");

        // Two corrupted reference bytes
        ref_mem[3] = ref_mem[3] ^ 8'h01;
        ref_mem[15] = ref_mem[15] ^ 8'h80;
        run_full("mm2");

        // All corrupted: count saturates at 16
        for (int a = 0; a < 16; a++) ref_mem[a] = ~(cipher_mem[a] ^ key_mem[a]);
        run_full("mm16");

        // Abort: en drops after cycle 8
        wr_cnt = 0; wr_cnt2 = 0; first_wr = -1;
        push_all();
        en = 1'b1;
        for (int c = 0; c <= 8; c++) @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("abort_wrcnt", wr_cnt, 6);
        check("abort_wrcnt2", wr_cnt2, 6);
        check("abort_we", W_E, 0);
        check("abort_fin", finished, 0);
        check("abort_mm", mm, model_mm(15, 6));
        check("abort_mm2", mm2, model_mm(3, 6));
        q1.delete();
        q2.delete();
        @(negedge clk);
        run_full("rerun");

        // Reset mid-run at cycle 10
        wr_cnt = 0; wr_cnt2 = 0; first_wr = -1;
        push_all();
        en = 1'b1;
        for (int c = 0; c <= 9; c++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("midreset_wrcnt", wr_cnt, 7);
        check("midreset_fin", finished, 0);
        q1.delete();
        q2.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
